pc_next_unit: RTL and testbench
===============================

// Module: pc_next_unit
// PURPOSE
//   Program-counter stage for the single-cycle MIPS datapath: holds PC, selects the
//   next PC (sequential / branch / jump / jump-register) and updates PC every cycle.
//   Consumes the branch-decision output 'jump' of the comparator stage and the NPCOp
//   control from the controller. Feeds the instruction memory address and the JAL link value.
//   Traps illegal fetch targets with a sticky error flag; counts retired PCs.
// PARAMETERS
//   IM_BASE   32'h0000_3000  reset PC; lowest legal fetch address
//   IM_DEPTH  4096           instruction memory size in words; legal range [IM_BASE, IM_BASE+4*IM_DEPTH)
// PORTS
//   clk       in   1   system clock, rising edge
//   reset     in   1   asynchronous, active-high reset
//   en        in   1   1: PC may advance this cycle; 0: hold PC (stall)
//   jump      in   1   branch-taken from comparator; used only when NPCOp==BRANCH
//   NPCOp     in   3   0 PC4, 1 BRANCH, 2 J/JAL, 3 JR; 4-7 treated as PC4
//   imm16     in   16  branch offset (words, signed)
//   imm26     in   26  jump index
//   ra        in   32  JR target (GPR[rs])
//   pc        out  32  current PC (instruction fetch address)
//   pc4       out  32  pc+4 (JAL link value / GPR write data)
//   npc       out  32  combinational next-PC candidate
//   pc_err    out  1   sticky: an illegal target was rejected
//   retired   out  32  count of accepted PC updates
// BEHAVIOUR
// - Reset (async, immediate on reset=1):
//   - pc=IM_BASE, pc_err=0, retired=0.
//   - Dominates all other inputs while high.
// - Combinational:
//   - pc4 = pc+4, 32-bit wrap.
//   - npc by NPCOp:
//     - PC4: pc+4.
//     - BRANCH: jump ? pc+4+{{14{imm16[15]}},imm16,2'b00} : pc+4.
//     - J: {pc[31:28],imm26,2'b00}.
//     - JR: ra.
//   - All adds modulo 2^32.
// - Legality of npc:
//   - npc[1:0]==0, and IM_BASE <= npc <= IM_BASE+4*IM_DEPTH-4.
//   - Compare is unsigned, 33-bit wide to avoid overflow in the upper bound.
// - Rising clk edge, reset=0: state machine is implicit in pc_err.
//   - RUN (pc_err=0):
//     - en=1 and npc legal: pc<=npc, retired<=retired+1 (wraps 32'hFFFF_FFFF -> 0).
//     - en=1 and npc illegal: pc holds, retired holds, pc_err<=1 (enter HALT).
//     - en=0: everything holds; legality is not evaluated, so no error is flagged.
//   - HALT (pc_err=1):
//     - pc and retired frozen regardless of en and NPCOp.
//     - Only reset exits HALT.
// - Latency: new pc is visible 1 cycle after the edge at which it is selected.
//   - npc reflects input changes in the same cycle, with no register.
// - Boundaries:
//   - Last legal word (IM_BASE+4*IM_DEPTH-4) with NPCOp=PC4: pc+4 is out of range,
//     so that edge sets pc_err.
//   - Branch offset 0 (taken) equals pc+4.
//   - imm16=16'hFFFF with jump=1 targets pc, i.e. a self-loop, which is legal.
//   - jump is ignored for every NPCOp other than BRANCH.
//   - Reset asserted mid-cycle clears pc_err and returns pc to IM_BASE without a clock edge.
// TESTING
// 1 Reset:
//   - assert reset between edges -> pc=0x3000, retired=0, pc_err=0 immediately.
//   - release, NPCOp=0, en=1, 3 edges -> pc=0x300C, retired=3.
// 2 Branch at pc=0x3010, NPCOp=1:
//   - imm16=0x0004, jump=1 -> pc=0x3024.
//   - imm16=0xFFFF, jump=1 -> pc=0x3010.
//   - jump=0 -> pc=0x3014.
// 3 Jumps at pc=0x3000:
//   - NPCOp=2, imm26=0x0000C10 -> pc=0x3040 (pc4=0x3004 before the edge).
//   - then NPCOp=3, ra=0x3100 -> pc=0x3100.
// 4 Stall: en=0 for 4 edges with NPCOp=2 -> pc and retired unchanged; npc still shows target.
// 5 Illegal targets:
//   - NPCOp=3, ra=0x3102 -> pc holds, pc_err=1.
//   - following edges with legal inputs -> pc still frozen, retired frozen; reset clears.
// 6 Range end:
//   - pc=0x6FFC (IM_DEPTH=4096), NPCOp=0 -> pc_err=1, pc stays 0x6FFC.
//   - separately, ra=0x2FFC via JR -> pc_err=1.

Source files
------------

// File: rtl/pc_next_unit.sv
// Program-counter stage: holds PC, picks the next fetch address,
// traps illegal targets with a sticky error and counts retired PCs.
module pc_next_unit #(
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_DEPTH = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        jump,
    input  logic [2:0]  NPCOp,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] ra,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] npc,
    output logic        pc_err,
    output logic [31:0] retired
);

    localparam logic [2:0] OP_PC4    = 3'd0;
    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_J      = 3'd2;
    localparam logic [2:0] OP_JR     = 3'd3;

    // Bounds kept 33 bits wide so the top of a large window cannot wrap.
    localparam logic [32:0] LO_ADDR = {1'b0, IM_BASE};
    localparam logic [32:0] HI_ADDR = LO_ADDR + 33'(4 * IM_DEPTH) - 33'd4;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ret_q, ret_d;
    logic        err_q, err_d;
    logic [31:0] br_off;
    logic [32:0] npc_ext;
    logic        npc_ok;

    assign pc4    = pc_q + 32'd4;
    assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        npc = pc4;
        case (NPCOp)
            OP_BRANCH: npc = jump ? pc4 + br_off : pc4;
            OP_J:      npc = {pc_q[31:28], imm26, 2'b00};
            OP_JR:     npc = ra;
            default:   npc = pc4;
        endcase
    end

    assign npc_ext = {1'b0, npc};
    assign npc_ok  = (npc[1:0] == 2'b00)
                   && (npc_ext >= LO_ADDR)
                   && (npc_ext <= HI_ADDR);

    // The sticky error flag doubles as the RUN/HALT state.
    always_comb begin
        pc_d  = pc_q;
        ret_d = ret_q;
        err_d = err_q;
        if (!err_q && en) begin
            if (npc_ok) begin
                pc_d  = npc;
                ret_d = ret_q + 32'd1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= IM_BASE;
            ret_q <= 32'd0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ret_q <= ret_d;
            err_q <= err_d;
        end
    end

    assign pc      = pc_q;
    assign pc_err  = err_q;
    assign retired = ret_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Randomized and directed bench for pc_next_unit against an
// arithmetic reference model of the PC update rules.
module tb_pc_next_unit;

    localparam longint BASE  = 64'h3000;
    localparam longint DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        jump = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] imm16 = 16'd0;
    logic [25:0] imm26 = 26'd0;
    logic [31:0] ra = 32'd0;
    logic [31:0] pc, pc4, npc, retired;
    logic        pc_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc = 32'h3000;
    logic [31:0] m_ret = 32'd0;
    logic        m_err = 1'b0;

    pc_next_unit dut (
        .clk(clk), .reset(reset), .en(en), .jump(jump),
        .NPCOp(op), .imm16(imm16), .imm26(imm26), .ra(ra),
        .pc(pc), .pc4(pc4), .npc(npc),
        .pc_err(pc_err), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_npc();
        longint p = longint'(m_pc);
        longint t;
        case (op)
            3'd1: t = jump ? p + 4 + longint'($signed(imm16)) * 4 : p + 4;
            3'd2: t = (p & 64'hF000_0000) | (longint'(imm26) * 4);
            3'd3: t = longint'(ra);
            default: t = p + 4;
        endcase
        return t[31:0];
    endfunction

    function automatic bit ref_legal(input logic [31:0] a);
        longint v = longint'(a);
        return (v % 4 == 0) && (v >= BASE) && (v <= BASE + 4 * DEPTH - 4);
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".err"}, {31'd0, pc_err}, {31'd0, m_err});
        chk({tag, ".ret"}, retired, m_ret);
    endtask

    // Check combinational outputs, advance the model, clock once, recheck.
    task automatic cyc();
        logic [31:0] n;
        #1;
        n = ref_npc();
        chk("npc", npc, n);
        chk("pc4", pc4, m_pc + 32'd4);
        if (!m_err && en) begin
            if (ref_legal(n)) begin
                m_pc  = n;
                m_ret = m_ret + 32'd1;
            end else begin
                m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_state("edge");
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1;
        m_pc  = 32'h3000;
        m_ret = 32'd0;
        m_err = 1'b0;
        #1;
        check_state("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        en = 1'b1; op = 3'd0;
        repeat (3) cyc();
        chk("t1.pc", pc, 32'h300C);
        chk("t1.ret", retired, 32'd3);

        op = 3'd3; ra = 32'h3010; cyc();
        op = 3'd1; imm16 = 16'h0004; jump = 1'b1; cyc();
        chk("t2.fwd", pc, 32'h3024);
        op = 3'd3; ra = 32'h3010; cyc();
        op = 3'd1; imm16 = 16'hFFFF; jump = 1'b1; cyc();
        chk("t2.self", pc, 32'h3010);
        jump = 1'b0; cyc();
        chk("t2.nt", pc, 32'h3014);

        do_reset();
        op = 3'd2; imm26 = 26'h0000C10; jump = 1'b1;
        #1;
        chk("t3.pc4", pc4, 32'h3004);
        cyc();
        chk("t3.j", pc, 32'h3040);
        op = 3'd3; ra = 32'h3100; cyc();
        chk("t3.jr", pc, 32'h3100);

        en = 1'b0; op = 3'd2; imm26 = 26'h0000C10;
        repeat (4) cyc();
        chk("t4.pc", pc, 32'h3100);
        chk("t4.npc", npc, 32'h3040);

        en = 1'b1; op = 3'd3; ra = 32'h3102; cyc();
        chk("t5.err", {31'd0, pc_err}, 32'd1);
        chk("t5.pc", pc, 32'h3100);
        ra = 32'h3200;
        repeat (3) cyc();
        chk("t5.frz", pc, 32'h3100);
        do_reset();

        op = 3'd3; ra = 32'h6FFC; cyc();
        op = 3'd0; cyc();
        chk("t6.err", {31'd0, pc_err}, 32'd1);
        chk("t6.pc", pc, 32'h6FFC);
        do_reset();
        op = 3'd3; ra = 32'h2FFC; cyc();
        chk("t6.lo", {31'd0, pc_err}, 32'd1);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            if (m_err && ($urandom % 4 == 0)) do_reset();
            en    = ($urandom % 5) != 0;
            jump  = $urandom % 2;
            op    = 3'($urandom % 8);
            imm16 = 16'($signed($urandom_range(16)) - 8);
            if ($urandom % 8 == 0)
                imm26 = 26'($urandom);
            else
                imm26 = 26'($urandom_range(32'h1BFF, 32'hC00));
            ra = 32'h3000 + ($urandom_range(32'hFFF) << 2);
            if ($urandom % 8 == 0) ra = ra + 32'($urandom_range(3));
            if ($urandom % 16 == 0) ra = $urandom;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
